fir_param_pipe: RTL and testbench

//  Parametrised, pipelined direct-form FIR filter. Successor to the fixed 9-tap/11-bit lab filter.

---
 rtl/fir_pkg.sv | 60 ++++++
 rtl/fir_coef_bank.sv | 79 +++++++
 rtl/fir_param_pipe.sv | 157 +++++++++++++++
 tb/tb_fir_param_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared helpers for the parametrised FIR family: log2 helper,
//               accumulator width computation, default widths and the
//               accumulator-to-output saturation function with clip flag.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int DW_DEF = 11;
    localparam int CW_DEF = 11;
    localparam int OW_DEF = 11;

    // Result of a saturating narrowing: value (sign-extended to 64 bits) and
    // whether clipping took place.
    typedef struct packed {
        logic [63:0] val;
        logic        clipped;
    } sat_res_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Accumulator width large enough that summing n full-width products
    // can never overflow.
    function automatic int calc_aw(input int n, input int dw, input int cw);
        return dw + cw + clog2_f(n);
    endfunction

    // Clip a signed value into the signed ow-bit range.
    function automatic sat_res_t sat_clip(input logic signed [63:0] r, input int ow);
        sat_res_t          res;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi          = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo          = -(64'sd1 <<< (ow - 1));
        res.clipped = 1'b1;
        if (r > hi) begin
            res.val = hi;
        end else if (r < lo) begin
            res.val = lo;
        end else begin
            res.val     = r;
            res.clipped = 1'b0;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coef_bank.sv
`default_nettype none
// ============================================================================
// Module      : fir_coef_bank
// Description : Double-buffered coefficient storage. Single-tap writes land in
//               the shadow bank; a commit copies the whole shadow bank (including
//               a write on the same edge) into the active bank in one edge.
// Ports       : clk_i, rst_i (async, active-high)
//               cw_en_i / cw_addr_i / cw_data_i : shadow write
//               cw_commit_i                     : shadow -> active copy
//               h_act_o                         : flattened active taps, tap i
//                                                 at [i*CW +: CW]
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int N_TAPS = 9,
    parameter int CW     = CW_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cw_en_i,
    input  logic [$clog2(N_TAPS)-1:0] cw_addr_i,
    input  logic [CW-1:0]             cw_data_i,
    input  logic                      cw_commit_i,
    output logic [N_TAPS*CW-1:0]      h_act_o
);

    localparam int                c_addr_w = $clog2(N_TAPS);
    localparam logic [c_addr_w:0] c_ntaps  = (c_addr_w + 1)'(N_TAPS);

    logic [CW-1:0] shadow_q [N_TAPS];
    logic [CW-1:0] shadow_d [N_TAPS];
    logic [CW-1:0] active_q [N_TAPS];
    logic [CW-1:0] active_d [N_TAPS];
    logic          w_addr_ok;

    // Addresses beyond the last tap are silently dropped.
    assign w_addr_ok = ({1'b0, cw_addr_i} < c_ntaps);

    always_comb begin
        shadow_d = shadow_q;
        if (cw_en_i && w_addr_ok) begin
            for (int i = 0; i < N_TAPS; i++) begin
                if (cw_addr_i == c_addr_w'(i)) begin
                    shadow_d[i] = cw_data_i;
                end
            end
        end
    end

    // Commit takes the post-write shadow so a same-edge write is included.
    always_comb begin
        active_d = active_q;
        if (cw_commit_i) begin
            active_d = shadow_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_TAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_flat
            assign h_act_o[gi*CW +: CW] = active_q[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fir_param_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fir_param_pipe
// Description : Parametrised 3-stage pipelined direct-form FIR filter with
//               double-buffered coefficients, optional rounding and optional
//               output saturation.
//               Stage 0: delay line shift on vin_i
//               Stage 1: per-tap full-precision products
//               Stage 2: sum, round, shift, saturate/wrap -> registered output
// Ports       : clk_i, rst_i (async, active-high)
//               din_i / vin_i        : signed sample and its valid
//               cw_en_i / cw_addr_i / cw_data_i / cw_commit_i : coefficient load
//               dout_o / vout_o / sat_flag_o : registered result, valid, clip flag
// Revision    : 1.0 - initial release
// ============================================================================
module fir_param_pipe
    import fir_pkg::*;
#(
    parameter int N_TAPS = 9,
    parameter int DW     = DW_DEF,
    parameter int CW     = CW_DEF,
    parameter int OW     = OW_DEF,
    parameter int SHIFT  = 10,
    parameter int ROUND  = 0,
    parameter int SAT    = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DW-1:0]             din_i,
    input  logic                      vin_i,
    input  logic                      cw_en_i,
    input  logic [$clog2(N_TAPS)-1:0] cw_addr_i,
    input  logic [CW-1:0]             cw_data_i,
    input  logic                      cw_commit_i,
    output logic [OW-1:0]             dout_o,
    output logic                      vout_o,
    output logic                      sat_flag_o
);

    localparam int c_pw = DW + CW;
    localparam int c_aw = calc_aw(N_TAPS, DW, CW);
    localparam logic signed [c_aw:0] c_half =
        (c_aw + 1)'((ROUND != 0) ? (64'sd1 <<< (SHIFT - 1)) : 64'sd0);

    logic [DW-1:0]           x_q [N_TAPS];
    logic signed [c_pw-1:0]  p_q [N_TAPS];
    logic                    v0_q;
    logic                    v1_q;
    logic [N_TAPS*CW-1:0]    w_h_act;

    logic signed [c_aw-1:0]  w_acc;
    logic signed [c_aw:0]    w_rnd;
    logic signed [c_aw:0]    w_shr;
    logic signed [63:0]      w_r64;
    sat_res_t                w_sat;
    logic                    w_unused_bits;

    logic [OW-1:0]           dout_q;
    logic [OW-1:0]           dout_d;
    logic                    flag_q;
    logic                    flag_d;
    logic                    vout_q;

    fir_coef_bank #(
        .N_TAPS (N_TAPS),
        .CW     (CW)
    ) u_coef (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cw_en_i     (cw_en_i),
        .cw_addr_i   (cw_addr_i),
        .cw_data_i   (cw_data_i),
        .cw_commit_i (cw_commit_i),
        .h_act_o     (w_h_act)
    );

    // Stage 0: delay line only moves on an accepted sample.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_TAPS; i++) begin
                x_q[i] <= '0;
            end
            v0_q <= 1'b0;
        end else begin
            v0_q <= vin_i;
            if (vin_i) begin
                x_q[0] <= din_i;
                for (int i = 1; i < N_TAPS; i++) begin
                    x_q[i] <= x_q[i-1];
                end
            end
        end
    end

    // Stage 1: products are recomputed every edge; only the valid pipeline
    // decides whether a result is ever presented. Coefficients are sampled here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_TAPS; i++) begin
                p_q[i] <= '0;
            end
            v1_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_TAPS; i++) begin
                p_q[i] <= c_pw'($signed(x_q[i])) * c_pw'($signed(w_h_act[i*CW +: CW]));
            end
            v1_q <= v0_q;
        end
    end

    // Stage 2: sign-extended sum; accumulator is wide enough to never overflow.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            w_acc = w_acc + c_aw'(p_q[i]);
        end
    end

    // One extra bit keeps the rounding offset from overflowing the sum.
    assign w_rnd = (c_aw + 1)'(w_acc) + c_half;
    assign w_shr = w_rnd >>> SHIFT;
    assign w_r64 = 64'(w_shr);
    assign w_sat = sat_clip(w_r64, OW);

    // Upper bits of the clipped value are by construction a sign extension.
    assign w_unused_bits = ^w_sat.val[63:OW];

    always_comb begin
        dout_d = w_r64[OW-1:0];
        flag_d = 1'b0;
        if (SAT != 0) begin
            dout_d = w_sat.val[OW-1:0];
            flag_d = w_sat.clipped;
        end
    end

    // Data and flag only change with a valid result, so they hold otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_q <= '0;
            flag_q <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            vout_q <= v1_q;
            if (v1_q) begin
                dout_q <= dout_d;
                flag_q <= flag_d;
            end
        end
    end

    assign dout_o     = dout_q;
    assign vout_o     = vout_q;
    assign sat_flag_o = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_param_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_param_pipe
// Description : Scoreboard bench for fir_param_pipe. Two instances share the
//               stimulus: A uses truncation + saturation, B uses rounding +
//               wrap. A convolution model computes expected outputs at issue
//               time; a monitor pops and compares on every valid output and
//               checks hold behaviour and the fixed 2-edge latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_param_pipe;

    localparam int N  = 9;
    localparam int SH = 10;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [10:0] din       = '0;
    logic        vin       = 1'b0;
    logic        cw_en     = 1'b0;
    logic [3:0]  cw_addr   = '0;
    logic [10:0] cw_data   = '0;
    logic        cw_commit = 1'b0;

    logic [10:0] dout_a;
    logic [10:0] dout_b;
    logic        vout_a;
    logic        vout_b;
    logic        flag_a;
    logic        flag_b;

    fir_param_pipe #(.N_TAPS(9), .DW(11), .CW(11), .OW(11), .SHIFT(10), .ROUND(0), .SAT(1)) u_a (
        .clk_i(clk), .rst_i(rst), .din_i(din), .vin_i(vin), .cw_en_i(cw_en),
        .cw_addr_i(cw_addr), .cw_data_i(cw_data), .cw_commit_i(cw_commit),
        .dout_o(dout_a), .vout_o(vout_a), .sat_flag_o(flag_a)
    );

    fir_param_pipe #(.N_TAPS(9), .DW(11), .CW(11), .OW(11), .SHIFT(10), .ROUND(1), .SAT(0)) u_b (
        .clk_i(clk), .rst_i(rst), .din_i(din), .vin_i(vin), .cw_en_i(cw_en),
        .cw_addr_i(cw_addr), .cw_data_i(cw_data), .cw_commit_i(cw_commit),
        .dout_o(dout_b), .vout_o(vout_b), .sat_flag_o(flag_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        bit f;
        int t;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   sh   [N];
    int   act  [N];
    int   hist [N];
    int   last_d [2];
    bit   last_f [2];
    int   n_vec = 0;
    int   n_err = 0;

    // Plain convolution of the sample history with the active taps.
    function automatic exp_t ref_out(input bit rnd, input bit sat);
        longint acc;
        exp_t   e;
        acc = 0;
        for (int i = 0; i < N; i++) acc += longint'(hist[i]) * longint'(act[i]);
        if (rnd) acc += longint'(1) << (SH - 1);
        acc = acc >>> SH;
        e.f = 1'b0;
        e.t = 0;
        if (sat) begin
            if (acc > 1023) begin
                e.d = 1023;  e.f = 1'b1;
            end else if (acc < -1024) begin
                e.d = -1024; e.f = 1'b1;
            end else begin
                e.d = int'(acc);
            end
        end else begin
            e.d = ((int'(acc) % 2048) + 2048) % 2048;
            if (e.d >= 1024) e.d -= 2048;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    // One clock of stimulus; the model is advanced for the coming edge.
    task automatic drive(input bit v, input int d, input bit we, input int wa,
                         input int wd, input bit cm);
        exp_t e;
        @(negedge clk);
        vin = v; din = 11'(d); cw_en = we; cw_addr = 4'(wa);
        cw_data = 11'(wd); cw_commit = cm;
        if (we && wa < N) sh[wa] = wd;
        if (cm) act = sh;
        if (v) begin
            for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = d;
            e = ref_out(1'b0, 1'b1); e.t = cyc + 1; q_a.push_back(e);
            e = ref_out(1'b1, 1'b0); e.t = cyc + 1; q_b.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vin = 1'b0; cw_en = 1'b0; cw_commit = 1'b0;
        for (int i = 0; i < N; i++) begin
            sh[i] = 0; act[i] = 0; hist[i] = 0;
        end
        q_a.delete(); q_b.delete();
        for (int i = 0; i < 2; i++) begin
            last_d[i] = 0; last_f[i] = 1'b0;
        end
        #1;
        chk("rst_vout_a", int'(vout_a), 0);
        chk("rst_vout_b", int'(vout_b), 0);
        chk("rst_dout_a", int'($signed(dout_a)), 0);
        chk("rst_flag_a", int'(flag_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic mon(input int sel, input logic v, input logic signed [10:0] d, input logic f);
        exp_t e;
        bit   empty;
        empty = 1'b0;
        if (v) begin
            if (sel == 0) begin
                if (q_a.size() == 0) empty = 1'b1; else e = q_a.pop_front();
            end else begin
                if (q_b.size() == 0) empty = 1'b1; else e = q_b.pop_front();
            end
            n_vec++;
            if (empty) begin
                n_err++;
                $display("FAIL unexpected_out[%0d]: got dout %0d with no pending sample", sel, int'(d));
                last_d[sel] = int'(d); last_f[sel] = f;
            end else if (int'(d) != e.d || f != e.f || cyc != e.t + 2) begin
                n_err++;
                $display("FAIL out[%0d]: got dout %0d flag %0d edge %0d, expected dout %0d flag %0d edge %0d",
                         sel, int'(d), f, cyc, e.d, e.f, e.t + 2);
                last_d[sel] = e.d; last_f[sel] = e.f;
            end else begin
                last_d[sel] = e.d; last_f[sel] = e.f;
            end
        end else begin
            n_vec++;
            if (int'(d) != last_d[sel] || f != last_f[sel]) begin
                n_err++;
                $display("FAIL hold[%0d]: got dout %0d flag %0d, expected held %0d flag %0d",
                         sel, int'(d), f, last_d[sel], last_f[sel]);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                mon(0, vout_a, $signed(dout_a), flag_a);
                mon(1, vout_b, $signed(dout_b), flag_b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        do_reset();

        // Zero coefficients after reset: outputs must be 0.
        for (int i = 0; i < 3; i++) drive(1'b1, 700 - i * 500, 1'b0, 0, 0, 1'b0);
        idle(3);

        // Impulse through h = 1..9; commit together with the last write.
        for (int i = 0; i < N; i++) drive(1'b0, 0, 1'b1, i, i + 1, i == N - 1);
        drive(1'b1, 1023, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < N - 1; i++) drive(1'b1, 0, 1'b0, 0, 0, 1'b0);
        idle(3);

        // Saturation: all taps 1023, full-scale input.
        for (int i = 0; i < N; i++) drive(1'b0, 0, 1'b1, i, 1023, i == N - 1);
        for (int i = 0; i < N; i++) drive(1'b1, 1023, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < N; i++) drive(1'b1, -1024, 1'b0, 0, 0, 1'b0);
        idle(3);

        // Commit atomicity: stream constant input while rewriting all taps.
        for (int i = 0; i < N; i++) drive(1'b0, 0, 1'b1, i, i + 1, i == N - 1);
        for (int c = 0; c < 24; c++) begin
            if (c >= 2 && c < 2 + N)
                drive(1'b1, 100, 1'b1, c - 2, 300 - (c - 2) * 71, c == 1 + N);
            else
                drive(1'b1, 100, 1'b0, 0, 0, 1'b0);
        end
        idle(3);

        // Same-edge write+commit on tap 0, then out-of-range writes.
        drive(1'b1, 512, 1'b1, 0, 5, 1'b1);
        drive(1'b0, 0, 1'b1, 9, 777, 1'b0);
        drive(1'b0, 0, 1'b1, 15, -333, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, -300 + i * 250, 1'b0, 0, 0, 1'b0);
        idle(3);

        // Reset with two samples in flight; nothing may come out for them.
        drive(1'b1, 900, 1'b0, 0, 0, 1'b0);
        drive(1'b1, -900, 1'b0, 0, 0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1000 - i * 900, 1'b0, 0, 0, 1'b0);
        idle(3);

        // Random traffic: ~30% valid, sparse coefficient writes and commits.
        for (int i = 0; i < N; i++)
            drive(1'b0, 0, 1'b1, i, int'($urandom_range(0, 2047)) - 1024, i == N - 1);
        for (int c = 0; c < 400; c++) begin
            d = int'($urandom_range(0, 2047)) - 1024;
            drive($urandom_range(0, 99) < 30, d,
                  $urandom_range(0, 99) < 10, int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 2047)) - 1024,
                  $urandom_range(0, 99) < 3);
        end
        idle(6);

        chk("pending_a", q_a.size(), 0);
        chk("pending_b", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
